// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-ported MIPS register file
package regfile_pkg;
    localparam int ST_W = 1;
    typedef enum logic [ST_W-1:0] {RF_IDLE, RF_CLEAR} rf_state_t;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) ;
        return r;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: next read-data for one port, with write-first bypass and clear bypass
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0]        rd_val,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic                     clr_act,
    input  logic [ADDR_W-1:0]        cnt,
    output logic [DATA_W-1:0]        nxt
);
    always_comb begin
        nxt = rd_val;
        for (int k = 0; k < NUM_WR; k++)
            if (!clr_act && we[k] && waddr[k*ADDR_W +: ADDR_W] == raddr)
                nxt = wdata[k*DATA_W +: DATA_W];
        if (clr_act && cnt == raddr)
            nxt = '0;
        // out-of-range or hardwired-zero reads override everything
        if ((ZERO_REG != 0 && raddr == '0) || int'(raddr) >= DEPTH)
            nxt = '0;
    end
endmodule

// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp: NUM_RD x NUM_WR register file with write-first reads
// and a one-entry-per-cycle clear sequencer.
module mips_regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     busy
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_val [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rdata_nxt;
    rf_state_t state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic clr_act;

    assign clr_act = state == RF_CLEAR;
    assign busy = clr_act;

    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        if (state == RF_IDLE && clr_req) begin
            state_nxt = RF_CLEAR;
            cnt_nxt = '0;
        end else if (clr_act) begin
            state_nxt = int'(cnt) == DEPTH - 1 ? RF_IDLE : RF_CLEAR;
            cnt_nxt = int'(cnt) == DEPTH - 1 ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RF_IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end

    // ascending port order makes the highest-index port win a conflict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clr_act) begin
            mem[cnt] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++)
                if (we[k] && int'(waddr[k*ADDR_W +: ADDR_W]) < DEPTH &&
                    (ZERO_REG == 0 || waddr[k*ADDR_W +: ADDR_W] != '0))
                    mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        assign rd_val[j] = int'(raddr[j*ADDR_W +: ADDR_W]) < DEPTH ?
                           mem[raddr[j*ADDR_W +: ADDR_W]] : '0;
        rf_read_port #(
            .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
            .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
        ) u_rd (
            .rd_val(rd_val[j]),
            .raddr(raddr[j*ADDR_W +: ADDR_W]),
            .we(we),
            .waddr(waddr),
            .wdata(wdata),
            .clr_act(clr_act),
            .cnt(cnt),
            .nxt(rdata_nxt[j*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else
            rdata <= rdata_nxt;
    end
endmodule
